// File: rtl/alu_ctrl_pkg.sv
// Shared opcode numbering, six-bit ALU control words and FSM state encoding
// for the ALU control-word encoder.
package alu_ctrl_pkg;

   localparam logic [3:0] OP_MOV     = 4'd0;
   localparam logic [3:0] OP_ADD     = 4'd1;
   localparam logic [3:0] OP_SUB     = 4'd2;
   localparam logic [3:0] OP_AND     = 4'd3;
   localparam logic [3:0] OP_OR      = 4'd4;
   localparam logic [3:0] OP_XOR     = 4'd5;
   localparam logic [3:0] OP_NOT     = 4'd6;
   localparam logic [3:0] OP_INC     = 4'd7;
   localparam logic [3:0] OP_DEC     = 4'd8;
   localparam logic [3:0] OP_SLL     = 4'd9;
   localparam logic [3:0] OP_SLA     = 4'd10;
   localparam logic [3:0] OP_ROL     = 4'd11;
   localparam logic [3:0] OP_SRL     = 4'd12;
   localparam logic [3:0] OP_SRA     = 4'd13;
   localparam logic [3:0] OP_ROR     = 4'd14;
   localparam logic [3:0] OP_ILLEGAL = 4'd15;

   localparam logic [5:0] CW_MOV = 6'b000000;
   localparam logic [5:0] CW_ADD = 6'b010010;
   localparam logic [5:0] CW_SUB = 6'b010001;
   localparam logic [5:0] CW_AND = 6'b000110;
   localparam logic [5:0] CW_OR  = 6'b001010;
   localparam logic [5:0] CW_XOR = 6'b001110;
   localparam logic [5:0] CW_NOT = 6'b001100;
   localparam logic [5:0] CW_INC = 6'b011011;
   localparam logic [5:0] CW_DEC = 6'b011000;
   localparam logic [5:0] CW_SLL = 6'b100000;
   localparam logic [5:0] CW_SLA = 6'b100100;
   localparam logic [5:0] CW_ROL = 6'b100010;
   localparam logic [5:0] CW_SRL = 6'b101000;
   localparam logic [5:0] CW_SRA = 6'b101100;
   localparam logic [5:0] CW_ROR = 6'b101010;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/alu_ctrl_rom.sv
// Combinational opcode decode: control word, shift-class flag and legality.
module alu_ctrl_rom
   import alu_ctrl_pkg::*;
(
   input  logic [3:0] i_op_code,
   output logic [5:0] o_ctrl,
   output logic       o_is_shift,
   output logic       o_legal
);

   always_comb begin
      o_ctrl  = CW_MOV;
      o_legal = 1'b1;
      case (i_op_code)
         OP_MOV:     o_ctrl = CW_MOV;
         OP_ADD:     o_ctrl = CW_ADD;
         OP_SUB:     o_ctrl = CW_SUB;
         OP_AND:     o_ctrl = CW_AND;
         OP_OR:      o_ctrl = CW_OR;
         OP_XOR:     o_ctrl = CW_XOR;
         OP_NOT:     o_ctrl = CW_NOT;
         OP_INC:     o_ctrl = CW_INC;
         OP_DEC:     o_ctrl = CW_DEC;
         OP_SLL:     o_ctrl = CW_SLL;
         OP_SLA:     o_ctrl = CW_SLA;
         OP_ROL:     o_ctrl = CW_ROL;
         OP_SRL:     o_ctrl = CW_SRL;
         OP_SRA:     o_ctrl = CW_SRA;
         OP_ROR:     o_ctrl = CW_ROR;
         OP_ILLEGAL: o_legal = 1'b0;
      endcase
      o_is_shift = (i_op_code >= OP_SLL) && (i_op_code <= OP_ROR);
   end

endmodule

// File: rtl/alu_ctrl_encoder.sv
// Issue-side ALU control encoder: accepts an op request, drives the control
// word for one or N cycles, then pulses done with the captured carry.
module alu_ctrl_encoder
   import alu_ctrl_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [3:0]       op_code,
   input  logic [CNT_W-1:0] op_count,
   input  logic             c_flag,
   output logic [5:0]       ctrl,
   output logic             alu_en,
   output logic             done,
   output logic             c_flag_out,
   output logic             err
);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [5:0]       r_ctrl;
   logic             r_ready;
   logic             r_alu_en;
   logic             r_done;
   logic             r_err;
   logic             r_cflag;

   logic [5:0]       w_ctrl;
   logic             w_is_shift;
   logic             w_legal;
   logic [CNT_W-1:0] w_cnt_init;

   alu_ctrl_rom u_rom (
      .i_op_code  (op_code),
      .o_ctrl     (w_ctrl),
      .o_is_shift (w_is_shift),
      .o_legal    (w_legal)
   );

   // A zero repeat count still issues once; non-shift ops always issue once.
   assign w_cnt_init = (w_is_shift && (op_count != '0)) ? op_count : CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_ctrl   <= CW_MOV;
         r_ready  <= 1'b1;
         r_alu_en <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_cflag  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (op_valid) begin
                  r_ready <= 1'b0;
                  r_cnt   <= w_cnt_init;
                  if (w_legal) begin
                     r_ctrl   <= w_ctrl;
                     r_alu_en <= 1'b1;
                     r_state  <= S_ISSUE;
                  end else begin
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end
            S_ISSUE: begin
               // Last live cycle: carry reflects the final ALU step.
               if (r_cnt <= CNT_W'(1)) begin
                  r_cflag  <= c_flag;
                  r_ctrl   <= CW_MOV;
                  r_alu_en <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_err   <= 1'b0;
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_state  <= S_IDLE;
               r_ctrl   <= CW_MOV;
               r_alu_en <= 1'b0;
               r_done   <= 1'b0;
               r_err    <= 1'b0;
               r_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign op_ready   = r_ready;
   assign ctrl       = r_ctrl;
   assign alu_en     = r_alu_en;
   assign done       = r_done;
   assign err        = r_err;
   assign c_flag_out = r_cflag;

endmodule

// File: tb/tb_alu_ctrl_encoder.sv
// Bench for alu_ctrl_encoder: timeline-based reference model checked every
// cycle, plus directed literal checks of the main scenarios.
module tb_alu_ctrl_encoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       op_valid;
   logic       op_ready;
   logic [3:0] op_code;
   logic [3:0] op_count;
   logic       c_flag;
   logic [5:0] ctrl;
   logic       alu_en;
   logic       done;
   logic       c_flag_out;
   logic       err;

   int checks = 0;
   int errors = 0;

   alu_ctrl_encoder #(.CNT_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .op_code    (op_code),
      .op_count   (op_count),
      .c_flag     (c_flag),
      .ctrl       (ctrl),
      .alu_en     (alu_en),
      .done       (done),
      .c_flag_out (c_flag_out),
      .err        (err)
   );

   always #5 clk = ~clk;

   logic [5:0] cw_tab [0:15] = '{
      6'b000000, 6'b010010, 6'b010001, 6'b000110,
      6'b001010, 6'b001110, 6'b001100, 6'b011011,
      6'b011000, 6'b100000, 6'b100100, 6'b100010,
      6'b101000, 6'b101100, 6'b101010, 6'b000000
   };

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: each accepted request occupies a timeline starting at
   // its accept edge a; N live cycles, then one done cycle.
   logic       m_init = 1'b0;
   logic       m_busy;
   int         m_k, m_a, m_n;
   logic       m_legal;
   logic [5:0] m_word;
   logic       m_cf;

   always @(posedge clk) begin
      logic       can_acc;
      logic       e_ready, e_alu, e_done, e_err;
      logic [5:0] e_ctrl;
      int         d;
      if (!rst_n) begin
         m_busy = 1'b0;
         m_cf   = 1'b0;
         m_k    = 0;
         m_init = 1'b1;
      end else if (m_init) begin
         m_k++;
         can_acc = !m_busy;
         if (m_busy && (m_k - m_a) > m_n) m_busy = 1'b0;
         if (can_acc && op_valid) begin
            m_busy  = 1'b1;
            m_a     = m_k;
            m_legal = (op_code != 4'd15);
            m_word  = cw_tab[op_code];
            if (!m_legal)                        m_n = 0;
            else if (op_code >= 9 && op_code <= 14) m_n = (op_count == 0) ? 1 : int'(op_count);
            else                                 m_n = 1;
         end
         e_ready = !m_busy;
         e_ctrl  = 6'b0;
         e_alu   = 1'b0;
         e_done  = 1'b0;
         e_err   = 1'b0;
         if (m_busy) begin
            d = m_k - m_a;
            if (d < m_n) begin
               e_ctrl = m_word;
               e_alu  = 1'b1;
            end else begin
               e_done = 1'b1;
               e_err  = !m_legal;
               if (m_legal) m_cf = c_flag;
            end
         end
         #1;
         if (rst_n) begin
            chk("m_ready", op_ready, e_ready);
            chk("m_ctrl", ctrl, e_ctrl);
            chk("m_alu_en", alu_en, e_alu);
            chk("m_done", done, e_done);
            chk("m_err", err, e_err);
            chk("m_cflag", c_flag_out, m_cf);
         end
      end
   end

   task automatic wait_ready();
      int t = 0;
      while (!op_ready && t < 60) begin
         @(negedge clk);
         t++;
      end
      chk("wait_ready", op_ready, 1'b1);
   endtask

   // Returns at the negedge of the first cycle after the accept edge.
   task automatic start_op(input logic [3:0] op, input logic [3:0] cnt);
      wait_ready();
      op_valid = 1'b1;
      op_code  = op;
      op_count = cnt;
      @(negedge clk);
      op_valid = 1'b0;
      op_code  = 4'($urandom);
      op_count = 4'($urandom);
   endtask

   task automatic wait_done();
      int t = 0;
      while (!done && t < 40) begin
         c_flag = 1'($urandom);
         @(negedge clk);
         t++;
      end
      chk("wait_done", done, 1'b1);
   endtask

   initial begin
      rst_n    = 1'b0;
      op_valid = 1'b0;
      op_code  = 4'd0;
      op_count = 4'd0;
      c_flag   = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ctrl", ctrl, 6'b0);
      chk("rst_ready", op_ready, 1'b1);
      chk("rst_alu_en", alu_en, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_cflag", c_flag_out, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // ADD with carry set during its single live cycle
      start_op(4'd1, 4'd0);
      chk("add_ctrl", ctrl, 6'b010010);
      chk("add_alu_en", alu_en, 1'b1);
      chk("add_ready", op_ready, 1'b0);
      c_flag = 1'b1;
      @(negedge clk);
      chk("add_done", done, 1'b1);
      chk("add_cflag", c_flag_out, 1'b1);
      chk("add_ctrl_off", ctrl, 6'b0);
      chk("add_err", err, 1'b0);
      @(negedge clk);
      chk("add_ready_back", op_ready, 1'b1);
      chk("add_done_off", done, 1'b0);

      // Sweep of all legal opcodes with count 0
      for (int op = 0; op < 15; op++) begin
         start_op(4'(op), 4'd0);
         chk("sweep_alu_en", alu_en, 1'b1);
         case (op)
            2:  chk("sweep_sub", ctrl, 6'b010001);
            7:  chk("sweep_inc", ctrl, 6'b011011);
            13: chk("sweep_sra", ctrl, 6'b101100);
            default: ;
         endcase
         wait_done();
      end

      // MOV with carry 0, then ROL x3 with carry 0,0,1
      c_flag = 1'b0;
      start_op(4'd0, 4'd0);
      c_flag = 1'b0;
      @(negedge clk);
      chk("mov_cflag", c_flag_out, 1'b0);
      @(negedge clk);
      start_op(4'd11, 4'd3);
      chk("rol_ctrl1", ctrl, 6'b100010);
      c_flag   = 1'b0;
      op_valid = 1'b1;
      op_code  = 4'd1;
      @(negedge clk);
      op_valid = 1'b0;
      chk("rol_ctrl2", ctrl, 6'b100010);
      chk("rol_alu_en2", alu_en, 1'b1);
      c_flag = 1'b0;
      @(negedge clk);
      chk("rol_ctrl3", ctrl, 6'b100010);
      chk("rol_no_done", done, 1'b0);
      c_flag = 1'b1;
      @(negedge clk);
      chk("rol_done", done, 1'b1);
      chk("rol_cflag", c_flag_out, 1'b1);
      chk("rol_alu_off", alu_en, 1'b0);
      @(negedge clk);

      // Illegal opcode keeps the carry and never enables the ALU
      c_flag = 1'b0;
      start_op(4'd15, 4'd7);
      chk("ill_done", done, 1'b1);
      chk("ill_err", err, 1'b1);
      chk("ill_alu_en", alu_en, 1'b0);
      chk("ill_ctrl", ctrl, 6'b0);
      chk("ill_cflag", c_flag_out, 1'b1);
      @(negedge clk);
      chk("ill_err_off", err, 1'b0);
      chk("ill_ready", op_ready, 1'b1);

      // Reset in the third live cycle of SRL x5
      start_op(4'd12, 4'd5);
      @(negedge clk);
      @(negedge clk);
      chk("srl_live3", ctrl, 6'b101000);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ctrl", ctrl, 6'b0);
      chk("mid_rst_alu_en", alu_en, 1'b0);
      chk("mid_rst_ready", op_ready, 1'b1);
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_cflag", c_flag_out, 1'b0);
      @(negedge clk);
      chk("mid_rst_no_done", done, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      start_op(4'd1, 4'd0);
      chk("post_rst_add", ctrl, 6'b010010);
      c_flag = 1'b1;
      @(negedge clk);
      chk("post_rst_done", done, 1'b1);
      chk("post_rst_cflag", c_flag_out, 1'b1);

      // Random traffic, including requests while busy
      repeat (2000) begin
         @(negedge clk);
         op_valid = ($urandom_range(0, 2) == 0);
         op_code  = 4'($urandom);
         op_count = 4'($urandom);
         c_flag   = 1'($urandom);
      end
      @(negedge clk);
      op_valid = 1'b0;
      repeat (25) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
